// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use, branch mispredict, RET hold, halt.
// Outputs are combinational from state and current stage inputs.
module pipe_ctrl #(
  parameter logic [7:0] RNONE     = 8'h0F,
  parameter int         RET_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  d_icode,
  input  logic [7:0]  d_srcA,
  input  logic [7:0]  d_srcB,
  input  logic [7:0]  e_icode,
  input  logic [7:0]  e_dstM,
  input  logic        e_cnd,
  input  logic [7:0]  w_icode,
  output logic        f_stall,
  output logic        d_stall,
  output logic        w_stall,
  output logic        d_bubble,
  output logic        e_bubble,
  output logic        m_bubble,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  localparam logic [7:0] I_HALT   = 8'h00;
  localparam logic [7:0] I_MRMOVL = 8'h05;
  localparam logic [7:0] I_JXX    = 8'h07;
  localparam logic [7:0] I_RET    = 8'h09;
  localparam logic [7:0] I_POPL   = 8'h0B;
  localparam logic [1:0] RET_LAST = 2'(RET_DEPTH - 1);

  typedef enum logic {RUN, HALTED} st_t;

  st_t         st_q, st_d;
  logic [1:0]  ret_cnt_q, ret_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic mispredict, load_use, ret_hold;

  always_comb begin
    mispredict = (e_icode == I_JXX) && !e_cnd;
    load_use   = ((e_icode == I_MRMOVL) || (e_icode == I_POPL))
               && (e_dstM != RNONE)
               && ((e_dstM == d_srcA) || (e_dstM == d_srcB));
    ret_hold   = (ret_cnt_q != 2'd0) || (d_icode == I_RET);
  end

  always_comb begin
    f_stall     = 1'b0;
    d_stall     = 1'b0;
    w_stall     = 1'b0;
    d_bubble    = 1'b0;
    e_bubble    = 1'b0;
    m_bubble    = 1'b0;
    halted      = 1'b0;
    st_d        = st_q;
    ret_cnt_d   = ret_cnt_q;
    stall_cnt_d = stall_cnt_q;
    unique case (st_q)
      RUN: begin
        if (mispredict) begin
          d_bubble = 1'b1;
          e_bubble = 1'b1;
          // a RET already past Decode keeps draining
          if (ret_cnt_q != 2'd0) ret_cnt_d = ret_cnt_q - 2'd1;
        end else if (load_use) begin
          f_stall  = 1'b1;
          d_stall  = 1'b1;
          e_bubble = 1'b1;
        end else if (ret_hold) begin
          f_stall  = 1'b1;
          d_bubble = 1'b1;
          ret_cnt_d = (ret_cnt_q == 2'd0) ? RET_LAST
                                          : ret_cnt_q - 2'd1;
        end
        if (w_icode == I_HALT) st_d = HALTED;
        if (f_stall && (stall_cnt_q != 16'hFFFF))
          stall_cnt_d = stall_cnt_q + 16'd1;
      end
      HALTED: begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        w_stall  = 1'b1;
        e_bubble = 1'b1;
        m_bubble = 1'b1;
        halted   = 1'b1;
      end
      default: st_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= RUN;
      ret_cnt_q   <= 2'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      st_q        <= st_d;
      ret_cnt_q   <= ret_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
